// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: raises one mole at a time from an LFSR, scores
// hits, charges misses against a life budget and reports the game state.
module whack_game_ctrl #(
   parameter int NUM_MOLES  = 4,
   parameter int UP_CYCLES  = 25_000_000,
   parameter int GAP_CYCLES = 5_000_000,
   parameter int LIVES      = 3,
   parameter int SCORE_W    = 8,
   localparam int IDX_W     = (NUM_MOLES > 2) ? $clog2(NUM_MOLES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 hit_valid,
   input  logic [IDX_W-1:0]     hit_idx,
   input  logic                 game_timeout,
   input  logic [15:0]          seed,
   output logic [2:0]           state,
   output logic [NUM_MOLES-1:0] mole_onehot,
   output logic [SCORE_W-1:0]   score,
   output logic [3:0]           lives,
   output logic                 game_over
);

   // state | meaning
   // IDLE  | waiting for start
   // ARM   | one cycle: choose next mole, load up timer
   // UP    | mole raised, accepting hits
   // GAP   | blank interval between moles
   // OVER  | game finished, score/lives frozen
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_UP   = 3'd2,
      S_GAP  = 3'd3,
      S_OVER = 3'd4
   } state_t;

   localparam int CNT_MAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   state_t               cur_st, nxt_st;
   logic                 start_s, start_p, hit_valid_s, timeout_s;
   logic [IDX_W-1:0]     hit_idx_s;
   logic [1:0]           live;
   logic                 start_evt;
   logic [15:0]          lfsr;
   logic                 lfsr_fb;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [IDX_W-1:0]     mole_idx, idx_n, cand, pick;
   logic [SCORE_W-1:0]   score_n;
   logic [3:0]           lives_n, lives_dec;
   logic [NUM_MOLES-1:0] mole_n;
   logic                 go_n, hit_ok;

   // live[1] marks start_p as a genuine post-reset sample, so start held
   // through reset release never looks like a rising edge.
   assign start_evt = start_s & ~start_p & live[1];
   assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign cand      = IDX_W'(32'(lfsr) % NUM_MOLES);
   assign pick      = (cand != mole_idx) ? cand :
                      (cand == IDX_W'(NUM_MOLES - 1)) ? '0 : cand + IDX_W'(1);
   assign hit_ok    = hit_valid_s && (hit_idx_s == mole_idx);
   assign lives_dec = (lives != 4'd0) ? lives - 4'd1 : 4'd0;
   assign state     = cur_st;

   always_comb begin
      nxt_st  = cur_st;
      cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : '0;
      idx_n   = mole_idx;
      score_n = score;
      lives_n = lives;
      case (cur_st)
         S_IDLE: begin
            if (start_evt) begin
               score_n = '0;
               lives_n = 4'(LIVES);
               nxt_st  = S_ARM;
            end
         end
         S_ARM: begin
            if (timeout_s) begin
               nxt_st = S_OVER;
            end else begin
               idx_n  = pick;
               cnt_n  = CNT_W'(UP_CYCLES - 1);
               nxt_st = S_UP;
            end
         end
         S_UP: begin
            if (timeout_s) begin
               nxt_st = S_OVER;
            end else if (hit_ok) begin
               score_n = (score == '1) ? score : score + SCORE_W'(1);
               cnt_n   = CNT_W'(GAP_CYCLES - 1);
               nxt_st  = S_GAP;
            end else if (hit_valid_s) begin
               lives_n = lives_dec;
               if (lives_dec == 4'd0) nxt_st = S_OVER;
            end else if (cnt == '0) begin
               lives_n = lives_dec;
               cnt_n   = CNT_W'(GAP_CYCLES - 1);
               nxt_st  = (lives_dec == 4'd0) ? S_OVER : S_GAP;
            end
         end
         S_GAP: begin
            if (timeout_s)      nxt_st = S_OVER;
            else if (cnt == '0) nxt_st = S_ARM;
         end
         S_OVER: begin
            if (start_evt) nxt_st = S_IDLE;
         end
         default: nxt_st = S_IDLE;
      endcase
      mole_n = (nxt_st == S_UP) ? (NUM_MOLES'(1) << idx_n) : '0;
      go_n   = (nxt_st == S_OVER) && (cur_st != S_OVER);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         start_s     <= 1'b0;
         start_p     <= 1'b0;
         hit_valid_s <= 1'b0;
         hit_idx_s   <= '0;
         timeout_s   <= 1'b0;
         live        <= 2'b00;
         lfsr        <= (seed == 16'h0000) ? 16'h0001 : seed;
         cur_st      <= S_IDLE;
         cnt         <= '0;
         mole_idx    <= '0;
         score       <= '0;
         lives       <= 4'(LIVES);
         mole_onehot <= '0;
         game_over   <= 1'b0;
      end else begin
         start_s     <= start;
         start_p     <= start_s;
         hit_valid_s <= hit_valid;
         hit_idx_s   <= hit_idx;
         timeout_s   <= game_timeout;
         live        <= {live[0], 1'b1};
         lfsr        <= {lfsr[14:0], lfsr_fb};
         cur_st      <= nxt_st;
         cnt         <= cnt_n;
         mole_idx    <= idx_n;
         score       <= score_n;
         lives       <= lives_n;
         mole_onehot <= mole_n;
         game_over   <= go_n;
      end
   end

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl: event-level game model checked every cycle,
// directed game scenarios with literal expectations, then random play.
module tb_whack_game_ctrl;

   localparam int NM  = 4;
   localparam int UPC = 8;
   localparam int GPC = 4;
   localparam int LV  = 3;
   localparam int SW  = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          hit_valid = 1'b0;
   logic [1:0]    hit_idx = 2'd0;
   logic          game_timeout = 1'b0;
   logic [15:0]   seed = 16'h0000;
   logic [2:0]    state;
   logic [NM-1:0] mole_onehot;
   logic [SW-1:0] score;
   logic [3:0]    lives;
   logic          game_over;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   whack_game_ctrl #(.NUM_MOLES(NM), .UP_CYCLES(UPC), .GAP_CYCLES(GPC),
                     .LIVES(LV), .SCORE_W(SW)) dut (
      .clk(clk), .reset(reset), .start(start), .hit_valid(hit_valid),
      .hit_idx(hit_idx), .game_timeout(game_timeout), .seed(seed),
      .state(state), .mole_onehot(mole_onehot), .score(score),
      .lives(lives), .game_over(game_over));

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Game model: phases tracked as absolute edge deadlines, inputs seen one edge late.
   longint    edge_n = 0;
   longint    phase_end = 0;
   int        m_state = 0, m_score = 0, m_lives = LV, m_mole = 0;
   bit        m_go = 0;
   logic [15:0] m_lfsr = 16'h0001;
   bit        c_start = 0, c_valid = 0, p_start = 0, p_valid = 0, c_hv = 0, c_to = 0;
   int        c_hi = 0;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk) begin
      int  old, cand;
      bit  evt;
      edge_n++;
      if (!reset) begin
         m_state = 0; m_score = 0; m_lives = LV; m_mole = 0; m_go = 0;
         m_lfsr  = (seed == 16'h0) ? 16'h0001 : seed;
         c_start = 0; c_valid = 0; p_start = 0; p_valid = 0;
         c_hv = 0; c_to = 0; c_hi = 0;
      end else begin
         evt = c_valid && c_start && p_valid && !p_start;
         old = m_state;
         case (m_state)
            0: if (evt) begin m_score = 0; m_lives = LV; m_state = 1; end
            1: if (c_to) m_state = 4;
               else begin
                  cand = int'(m_lfsr) % NM;
                  if (cand == m_mole) cand = (cand + 1) % NM;
                  m_mole = cand; phase_end = edge_n + UPC; m_state = 2;
               end
            2: if (c_to) m_state = 4;
               else if (c_hv && c_hi == m_mole) begin
                  m_score = (m_score < 255) ? m_score + 1 : 255;
                  phase_end = edge_n + GPC; m_state = 3;
               end else if (c_hv) begin
                  m_lives--;
                  if (m_lives == 0) m_state = 4;
               end else if (edge_n >= phase_end) begin
                  m_lives--;
                  phase_end = edge_n + GPC;
                  m_state = (m_lives == 0) ? 4 : 3;
               end
            3: if (c_to) m_state = 4;
               else if (edge_n >= phase_end) m_state = 1;
            4: if (evt) m_state = 0;
            default: m_state = 0;
         endcase
         m_go   = (m_state == 4) && (old != 4);
         m_lfsr = lfsr_next(m_lfsr);
         p_start = c_start; p_valid = c_valid;
         c_start = start; c_valid = 1; c_hv = hit_valid; c_hi = int'(hit_idx); c_to = game_timeout;
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("cyc_state", state, m_state);
         check("cyc_mole", mole_onehot, (m_state == 2) ? (longint'(1) << m_mole) : 0);
         check("cyc_score", score, m_score);
         check("cyc_lives", lives, m_lives);
         check("cyc_game_over", game_over, m_go);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_state(input int s, input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         if (int'(state) == s) break;
         tick();
      end
      check(nm, state, s);
   endtask

   task automatic do_reset(input logic [15:0] sv);
      reset = 1'b0; start = 1'b0; hit_valid = 1'b0; game_timeout = 1'b0; seed = sv;
      tick(); tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic start_game();
      start = 1'b1; tick(); start = 1'b0;
      wait_state(2, 20, "reach_up");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, changes, gos, up_cnt, last_lives;
      logic [NM-1:0] oh0;
      tick();
      // reset with seed 0
      reset = 1'b0; seed = 16'h0000;
      tick(); tick();
      chk_en = 1;
      check("rst_state", state, 0);
      check("rst_lives", lives, 3);
      check("rst_score", score, 0);
      check("rst_mole", mole_onehot, 0);
      check("rst_lfsr", dut.lfsr, 16'h0001);
      check("rst_game_over", game_over, 0);

      // start held through reset release is not a start event
      start = 1'b1; tick(); reset = 1'b1;
      repeat (6) tick();
      check("held_start_idle", state, 0);
      start = 1'b0; tick();

      // correct hit mid-UP, then GAP/ARM/UP timing
      do_reset(16'h0000);
      start_game();
      tick(); tick();
      oh0 = mole_onehot;
      hit_valid = 1'b1; hit_idx = 2'(m_mole); tick();
      hit_valid = 1'b0; tick();
      check("hit_to_gap", state, 3);
      check("hit_score", score, 1);
      cnt = 0;
      while (state == 3'd3 && cnt < 20) begin cnt++; tick(); end
      check("gap_len", cnt, 4);
      cnt = 0;
      while (state == 3'd1 && cnt < 20) begin cnt++; tick(); end
      check("arm_len", cnt, 1);
      check("up_again", state, 2);
      check("new_mole_differs", mole_onehot != oh0, 1);

      // three unanswered moles end the game
      do_reset(16'hACE1);
      start_game();
      changes = 0; gos = 0; last_lives = lives;
      for (int i = 0; i < 200; i++) begin
         if (state == 3'd4) break;
         tick();
         if (int'(lives) != last_lives) begin changes++; last_lives = lives; end
         if (game_over) gos++;
      end
      check("miss_over_state", state, 4);
      check("miss_over_pulse", game_over, 1);
      check("miss_lives", lives, 0);
      check("miss_score", score, 0);
      check("miss_life_steps", changes, 3);
      tick();
      check("miss_pulse_once", game_over, 0);
      check("miss_hold_over", state, 4);

      // wrong hit keeps the mole up on its original schedule
      do_reset(16'h1234);
      start_game();
      oh0 = mole_onehot;
      up_cnt = 1;
      hit_valid = 1'b1; hit_idx = 2'((m_mole + 1) % NM); tick(); up_cnt++;
      hit_valid = 1'b0; tick(); up_cnt++;
      check("wrong_lives", lives, 2);
      check("wrong_stays_up", state, 2);
      check("wrong_same_mole", mole_onehot, oh0);
      forever begin
         tick();
         if (state != 3'd2 || up_cnt >= 30) break;
         up_cnt++;
      end
      check("wrong_up_len", up_cnt, 8);
      check("wrong_then_gap", state, 3);
      check("wrong_expiry_life", lives, 1);

      // timeout beats a simultaneous correct hit
      do_reset(16'h00FF);
      start_game();
      hit_valid = 1'b1; hit_idx = 2'(m_mole); game_timeout = 1'b1; tick();
      hit_valid = 1'b0; game_timeout = 1'b0; tick();
      check("to_over", state, 4);
      check("to_score", score, 0);
      check("to_lives", lives, 3);
      check("to_pulse", game_over, 1);

      // score saturation
      do_reset(16'h5A5A);
      start = 1'b1; tick(); start = 1'b0;
      for (int r = 0; r < 256; r++) begin
         wait_state(2, 30, "sat_up");
         hit_valid = 1'b1; hit_idx = 2'(m_mole); tick();
         hit_valid = 1'b0; tick();
         if (r == 254) check("sat_reach_255", score, 255);
      end
      check("sat_hold_255", score, 255);
      check("sat_lives", lives, 3);

      // random play against the model
      do_reset(16'(($urandom % 65535) + 1));
      for (int i = 0; i < 5000; i++) begin
         reset        = ($urandom_range(0, 599) != 0);
         if (!reset) seed = 16'($urandom);
         if ($urandom_range(0, 9) == 0) start = ~start;
         hit_valid    = ($urandom_range(0, 3) == 0);
         hit_idx      = 2'($urandom);
         game_timeout = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b1; hit_valid = 1'b0; game_timeout = 1'b0;
      tick(); tick();
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
